i2c_touch_target: RTL and testbench



---
 rtl/i2c_touch_target.sv | 274 +++++++++++++++++++++++++++
 tb/tb_i2c_touch_target.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_touch_target.sv
// ---------------------------------------------------------------------------
// i2c_touch_target
// I2C target that emulates the register bank of a capacitive touch controller.
// It lets the touch-panel I2C initiator be exercised without a physical panel.
// The fabric preloads registers through a local port and is told about every
// byte the initiator writes. SDA is open-drain: 0 pulls low, 1 releases.
// There is no clock stretching.
//
// Ports
//   clk        system clock
//   resetb     synchronous active-low reset
//   scl_in     raw SCL pin level
//   sda_in     raw SDA pin level
//   sda_out    0 = pull SDA low, 1 = release
//   loc_we     local register write strobe
//   loc_addr   local register index
//   loc_din    local write data
//   loc_dout   reg[loc_addr], one cycle after loc_addr
//   wr_strobe  one-cycle pulse per data byte written over I2C
//   wr_addr    register index of that write
//   wr_data    byte written
//   busy       high from an addressed START until STOP
// ---------------------------------------------------------------------------
module i2c_touch_target #(
    parameter logic [6:0] DEV_ADDR = 7'h38,
    parameter int         NREG     = 16,
    parameter int         FILT     = 3
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    scl_in,
    input  logic                    sda_in,
    output logic                    sda_out,
    input  logic                    loc_we,
    input  logic [$clog2(NREG)-1:0] loc_addr,
    input  logic [7:0]              loc_din,
    output logic [7:0]              loc_dout,
    output logic                    wr_strobe,
    output logic [$clog2(NREG)-1:0] wr_addr,
    output logic [7:0]              wr_data,
    output logic                    busy
);

    localparam int              PW      = $clog2(NREG);
    localparam logic [2:0]      FILT_M1 = 3'(FILT - 1);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ACK_A, ST_PTR, ST_WDATA, ST_ACK_W, ST_RDATA, ST_IGNORE
    } state_t;

    // Index 1 carries SCL, index 0 carries SDA.
    logic [1:0]    r_sync1, r_sync2, r_filt, r_filt_d;
    logic [2:0]    r_cnt [2];

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [7:0]    r_tx, w_tx_nxt;
    logic [PW-1:0] r_ptr, w_ptr_nxt;
    logic          r_sda_out, w_sda_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_wr_strobe, w_wr_nxt;
    logic [PW-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [7:0]    r_wr_data, w_wr_data_nxt;
    logic [7:0]    r_regs [NREG];
    logic [7:0]    r_loc_dout;

    logic          w_start, w_stop, w_rise, w_fall;
    logic [7:0]    w_byte;

    // Synchronize both pins, then accept a new level only once it has held for FILT clocks.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_sync1  <= 2'b11;
            r_sync2  <= 2'b11;
            r_filt   <= 2'b11;
            r_filt_d <= 2'b11;
            r_cnt[0] <= 3'd0;
            r_cnt[1] <= 3'd0;
        end else begin
            r_sync1  <= {scl_in, sda_in};
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i] <= 3'd0;
                end else if (r_cnt[i] == FILT_M1) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= 3'd0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 3'd1;
                end
            end
        end
    end

    assign w_start = r_filt_d[0] & ~r_filt[0] & r_filt[1];
    assign w_stop  = ~r_filt_d[0] & r_filt[0] & r_filt[1];
    assign w_rise  = ~r_filt_d[1] & r_filt[1];
    assign w_fall  = r_filt_d[1] & ~r_filt[1];
    assign w_byte  = {r_shift[6:0], r_filt[0]};

    // Protocol state register and its datapath.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state     <= ST_IDLE;
            r_bit       <= 4'd0;
            r_shift     <= 8'h00;
            r_tx        <= 8'h00;
            r_ptr       <= '0;
            r_sda_out   <= 1'b1;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_bit       <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_tx        <= w_tx_nxt;
            r_ptr       <= w_ptr_nxt;
            r_sda_out   <= w_sda_nxt;
            r_busy      <= w_busy_nxt;
            r_wr_strobe <= w_wr_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
        end
    end

    // Next-state logic; bus conditions override any SCL edge seen in the same clock.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_ptr_nxt     = r_ptr;
        w_sda_nxt     = r_sda_out;
        w_busy_nxt    = r_busy;
        w_wr_nxt      = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_bit_nxt   = 4'd0;
            w_sda_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
        end else if (w_start) begin
            w_state_nxt = ST_ADDR;
            w_bit_nxt   = 4'd0;
            w_sda_nxt   = 1'b1;
        end else begin
            case (r_state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (w_rise && (r_bit < 4'd8)) begin
                        w_shift_nxt = w_byte;
                        w_bit_nxt   = r_bit + 4'd1;
                        if ((r_bit == 4'd7) && (r_state == ST_PTR)) begin
                            w_ptr_nxt = w_byte[PW-1:0];
                        end else if ((r_bit == 4'd7) && (r_state == ST_WDATA)) begin
                            w_wr_nxt      = 1'b1;
                            w_wr_addr_nxt = r_ptr;
                            w_wr_data_nxt = w_byte;
                            w_ptr_nxt     = r_ptr + PTR_ONE;
                        end else begin
                            w_ptr_nxt = r_ptr;
                        end
                    end else if (w_fall && (r_bit == 4'd8)) begin
                        if ((r_state != ST_ADDR) || (r_shift[7:1] == DEV_ADDR)) begin
                            w_sda_nxt   = 1'b0;
                            w_busy_nxt  = 1'b1;
                            w_state_nxt = (r_state == ST_ADDR) ? ST_ACK_A : ST_ACK_W;
                        end else begin
                            w_state_nxt = ST_IGNORE;
                        end
                    end else begin
                        w_bit_nxt = r_bit;
                    end
                end
                ST_ACK_A: begin
                    if (w_fall) begin
                        w_bit_nxt = 4'd0;
                        // R/W bit is still in the shift register from the address byte.
                        if (r_shift[0]) begin
                            w_tx_nxt    = r_regs[r_ptr];
                            w_sda_nxt   = r_regs[r_ptr][7];
                            w_state_nxt = ST_RDATA;
                        end else begin
                            w_sda_nxt   = 1'b1;
                            w_state_nxt = ST_PTR;
                        end
                    end else begin
                        w_bit_nxt = r_bit;
                    end
                end
                ST_ACK_W: begin
                    if (w_fall) begin
                        w_sda_nxt   = 1'b1;
                        w_bit_nxt   = 4'd0;
                        w_state_nxt = ST_WDATA;
                    end else begin
                        w_bit_nxt = r_bit;
                    end
                end
                ST_RDATA: begin
                    // r_bit: 0..6 bits still to shift out, 7 = release for master ACK,
                    // 8 = waiting for master ACK rise, 9 = reload on next fall.
                    if (w_fall) begin
                        if (r_bit < 4'd7) begin
                            w_tx_nxt  = {r_tx[6:0], 1'b0};
                            w_sda_nxt = r_tx[6];
                            w_bit_nxt = r_bit + 4'd1;
                        end else if (r_bit == 4'd7) begin
                            w_sda_nxt = 1'b1;
                            w_bit_nxt = 4'd8;
                        end else if (r_bit == 4'd9) begin
                            w_tx_nxt  = r_regs[r_ptr];
                            w_sda_nxt = r_regs[r_ptr][7];
                            w_bit_nxt = 4'd0;
                        end else begin
                            w_bit_nxt = r_bit;
                        end
                    end else if (w_rise && (r_bit == 4'd8)) begin
                        // Pointer advances past every byte sent, acknowledged or not.
                        w_ptr_nxt = r_ptr + PTR_ONE;
                        if (r_filt[0]) begin
                            w_state_nxt = ST_IGNORE;
                        end else begin
                            w_bit_nxt = 4'd9;
                        end
                    end else begin
                        w_bit_nxt = r_bit;
                    end
                end
                ST_IGNORE: begin
                    w_sda_nxt = 1'b1;
                end
                ST_IDLE: begin
                    w_sda_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_sda_nxt   = 1'b1;
                end
            endcase
        end
    end

    // Register bank: the I2C write is placed last so it wins a same-clock collision.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_loc_dout <= 8'h00;
        end else begin
            if (loc_we) begin
                r_regs[loc_addr] <= loc_din;
            end
            if (r_wr_strobe) begin
                r_regs[r_wr_addr] <= r_wr_data;
            end
            r_loc_dout <= r_regs[loc_addr];
        end
    end

    assign sda_out   = r_sda_out;
    assign busy      = r_busy;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign loc_dout  = r_loc_dout;

endmodule

// File: tb/tb_i2c_touch_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_touch_target
// Directed bench: a bit-banged I2C initiator drives the target over a
// wired-AND SDA. Expected I2C register writes are queued when the stimulus
// is issued and a monitor pops and compares them on every wr_strobe. Read
// data, ACK bits and local readback are compared against hand values.
// ---------------------------------------------------------------------------
module tb_i2c_touch_target;

    localparam int Q = 16;  // quarter SCL period in clk cycles

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetb, scl_m, sda_m, loc_we;
    logic [3:0] loc_addr;
    logic [7:0] loc_din;
    wire        sda_out, wr_strobe, busy;
    wire  [7:0] loc_dout, wr_data;
    wire  [3:0] wr_addr;
    wire        sda_bus = sda_m & sda_out;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [11:0] exp_q [$];
    logic [11:0] mon_e;
    logic        collide_arm = 1'b0;
    logic        collide_on  = 1'b0;
    logic        ack;
    logic [7:0]  rd;
    logic [2:0]  rbits;

    i2c_touch_target #(.DEV_ADDR(7'h38), .NREG(16), .FILT(3)) dut (
        .clk       (clk),
        .resetb    (resetb),
        .scl_in    (scl_m),
        .sda_in    (sda_bus),
        .sda_out   (sda_out),
        .loc_we    (loc_we),
        .loc_addr  (loc_addr),
        .loc_din   (loc_din),
        .loc_dout  (loc_dout),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    // Scoreboard monitor: every wr_strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (resetb === 1'b1 && wr_strobe === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_strobe: got addr %h data %h, no write expected", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== mon_e) begin
                    n_fail++;
                    $display("FAIL wr_strobe: got addr %h data %h, expected addr %h data %h",
                             wr_addr, wr_data, mon_e[11:8], mon_e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n clocks; also fires the armed local write in the same clock as an I2C write.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (collide_on) begin
                loc_we     = 1'b0;
                collide_on = 1'b0;
            end
            if (collide_arm && wr_strobe === 1'b1) begin
                loc_we      = 1'b1;
                loc_addr    = 4'd5;
                loc_din     = 8'hAA;
                collide_arm = 1'b0;
                collide_on  = 1'b1;
            end
        end
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        if (glitch) begin
            sda_m = ~b;
            tick(1);
            sda_m = b;
            tick(Q - 1);
        end else begin
            tick(Q);
        end
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        b = sda_bus;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic [7:0] gmask, output logic a);
        for (int i = 7; i >= 0; i--) begin
            write_bit(d[i], gmask[i]);
        end
        read_bit(a);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic a);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(a, 1'b0);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(Q);
    endtask

    task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
        loc_addr = a;
        loc_din  = d;
        loc_we   = 1'b1;
        tick(1);
        loc_we   = 1'b0;
        tick(1);
    endtask

    task automatic loc_read(input logic [3:0] a, output logic [7:0] d);
        loc_addr = a;
        tick(2);
        d = loc_dout;
    endtask

    initial begin
        resetb   = 1'b0;
        scl_m    = 1'b1;
        sda_m    = 1'b1;
        loc_we   = 1'b0;
        loc_addr = 4'd0;
        loc_din  = 8'h00;
        tick(4);
        check("rst_sda_out",   sda_out,   1);
        check("rst_busy",      busy,      0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr",   wr_addr,   0);
        check("rst_wr_data",   wr_data,   0);
        check("rst_loc_dout",  loc_dout,  0);
        resetb = 1'b1;
        tick(10);

        // Preload and register read with repeated START.
        loc_write(4'd2, 8'h5A);
        loc_write(4'd3, 8'hC3);
        loc_write(4'd4, 8'h96);
        loc_read(4'd2, rd);
        check("loc_read_r2", rd, 8'h5A);
        i2c_start();
        write_byte(8'h70, 8'h00, ack);
        check("ack_addr_w", ack, 0);
        check("busy_after_addr", busy, 1);
        write_byte(8'h02, 8'h00, ack);
        check("ack_ptr", ack, 0);
        i2c_rstart();
        write_byte(8'h71, 8'h00, ack);
        check("ack_addr_r", ack, 0);
        read_byte(rd, 1'b0);
        check("read_r2", rd, 8'h5A);
        read_byte(rd, 1'b1);
        check("read_r3", rd, 8'hC3);
        i2c_stop();
        check("busy_after_stop", busy, 0);

        // Pointer persisted across STOP at 4.
        i2c_start();
        write_byte(8'h71, 8'h00, ack);
        check("ack_addr_r2", ack, 0);
        read_byte(rd, 1'b1);
        check("read_ptr4", rd, 8'h96);
        i2c_stop();

        // Burst write wrapping from 15 to 0.
        exp_q.push_back({4'hF, 8'h11});
        exp_q.push_back({4'h0, 8'h22});
        i2c_start();
        write_byte(8'h70, 8'h00, ack);
        check("wr_ack_addr", ack, 0);
        write_byte(8'h0F, 8'h00, ack);
        check("wr_ack_ptr", ack, 0);
        write_byte(8'h11, 8'h00, ack);
        check("wr_ack_d0", ack, 0);
        write_byte(8'h22, 8'h00, ack);
        check("wr_ack_d1", ack, 0);
        i2c_stop();
        check("wr_pending_wrap", exp_q.size(), 0);
        loc_read(4'd15, rd);
        check("loc_read_r15", rd, 8'h11);
        loc_read(4'd0, rd);
        check("loc_read_r0", rd, 8'h22);

        // Foreign address: no ACK, no busy, no writes.
        i2c_start();
        write_byte(8'h72, 8'h00, ack);
        check("nack_foreign", ack, 1);
        check("busy_foreign", busy, 0);
        write_byte(8'h01, 8'h00, ack);
        check("nack_foreign_b1", ack, 1);
        write_byte(8'h55, 8'h00, ack);
        check("nack_foreign_b2", ack, 1);
        i2c_stop();

        // One-clock SDA glitches while SCL high: fake STOP on bit 7, fake START on bit 6.
        exp_q.push_back({4'h6, 8'h77});
        i2c_start();
        write_byte(8'h70, 8'h00, ack);
        write_byte(8'h06, 8'h00, ack);
        write_byte(8'h77, 8'hC0, ack);
        check("glitch_ack", ack, 0);
        check("glitch_busy", busy, 1);
        i2c_stop();
        check("wr_pending_glitch", exp_q.size(), 0);
        loc_read(4'd6, rd);
        check("loc_read_r6", rd, 8'h77);

        // Local and I2C write to reg 5 in the same clock: I2C wins.
        exp_q.push_back({4'h5, 8'h55});
        i2c_start();
        write_byte(8'h70, 8'h00, ack);
        write_byte(8'h05, 8'h00, ack);
        collide_arm = 1'b1;
        write_byte(8'h55, 8'h00, ack);
        check("collide_ack", ack, 0);
        i2c_stop();
        check("wr_pending_collide", exp_q.size(), 0);
        loc_read(4'd5, rd);
        check("loc_read_r5", rd, 8'h55);

        // Reset while the target drives bit 4 of C3.
        i2c_start();
        write_byte(8'h70, 8'h00, ack);
        write_byte(8'h03, 8'h00, ack);
        i2c_rstart();
        write_byte(8'h71, 8'h00, ack);
        read_bit(rbits[2]);
        read_bit(rbits[1]);
        read_bit(rbits[0]);
        check("rd_bits_765", rbits, 3'b110);
        check("drive_bit4", sda_out, 0);
        resetb = 1'b0;
        tick(1);
        check("rst_mid_sda_out", sda_out, 1);
        check("rst_mid_busy", busy, 0);
        resetb = 1'b1;
        sda_m  = 1'b1;
        tick(Q);
        scl_m  = 1'b1;
        tick(2 * Q);
        loc_read(4'd3, rd);
        check("rst_mid_r3", rd, 8'h00);
        i2c_start();
        write_byte(8'h71, 8'h00, ack);
        check("rst_mid_ack", ack, 0);
        read_byte(rd, 1'b1);
        check("rst_mid_read_r0", rd, 8'h00);
        i2c_stop();

        tick(20);
        check("wr_pending_end", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
